// File: rtl/hack_mem_pkg.sv
// Shared constants and state encoding for the RAM512 self-test engine.
package hack_mem_pkg;

    localparam int RAM_AW = 9;
    localparam int RAM_DW = 16;
    localparam logic [RAM_DW-1:0] RAM_SEED = 16'h3021;

    // Run sequence: write/read pass 0, then write/read pass 1 with inverted data.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        WR1  = 3'd3,
        RD1  = 3'd4,
        DONE = 3'd5
    } bist_state_t;

endpackage

// File: rtl/ram512_bist_if.sv
// RAM port bundle: the BIST (master) drives address/data/load, the RAM (slave) returns read data.
// Read data is combinational from ram_address; a write happens on the rising clock edge
// whenever ram_load is 1, there is no valid/ready handshake on this port.
interface ram512_bist_if;
    import hack_mem_pkg::*;

    logic [RAM_DW-1:0] ram_in;
    logic [RAM_DW-1:0] ram_out;
    logic              ram_load;
    logic [RAM_AW-1:0] ram_address;

    modport master (
        output ram_in,
        output ram_load,
        output ram_address,
        input  ram_out
    );

    modport slave (
        input  ram_in,
        input  ram_load,
        input  ram_address,
        output ram_out
    );

endinterface

// File: rtl/ram512_bist_pattern.sv
// Combinational test-pattern generator: P(a,k) = SEED ^ a, inverted for pass 1.
module bist_pattern #(
    parameter int              AW   = 9,
    parameter int              DW   = 16,
    parameter logic [DW-1:0]   SEED = 16'h3021
) (
    input  logic [AW-1:0] a,
    input  logic          k,
    output logic [DW-1:0] p
);

    logic [DW-1:0] base;

    // Zero-extend the address, mix with the seed, invert on the second pass.
    always_comb begin
        base = SEED ^ {{(DW-AW){1'b0}}, a};
        p    = k ? ~base : base;
    end

endmodule

// File: rtl/ram512_bist.sv
// RAM512 self-test engine: two write/read-compare passes over every word,
// reporting pass/fail, mismatch count and the location of the first mismatch.
module ram512_bist
    import hack_mem_pkg::*;
#(
    parameter int              AW   = RAM_AW,
    parameter int              DW   = RAM_DW,
    parameter logic [DW-1:0]   SEED = RAM_SEED
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    ram512_bist_if.master   ram,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW+1:0]   err_count,
    output logic [AW-1:0]   fail_addr,
    output logic            fail_pass,
    output bist_state_t     state_dbg
);

    bist_state_t   state;
    logic [AW-1:0] counter;
    logic          is_wr;
    logic          is_rd;
    logic          pass_k;
    logic          last;
    logic          mismatch;
    logic [AW+1:0] err_next;
    logic [DW-1:0] pattern;

    bist_pattern #(
        .AW   (AW),
        .DW   (DW),
        .SEED (SEED)
    ) u_pattern (
        .a (counter),
        .k (pass_k),
        .p (pattern)
    );

    // Decode phase from state; RAM drive and compare result follow from state and counter.
    always_comb begin
        is_wr           = (state == WR0) || (state == WR1);
        is_rd           = (state == RD0) || (state == RD1);
        pass_k          = (state == WR1) || (state == RD1);
        last            = (counter == {AW{1'b1}});
        mismatch        = is_rd && (ram.ram_out != pattern);
        err_next        = err_count + {{(AW+1){1'b0}}, mismatch};
        ram.ram_load    = is_wr;
        ram.ram_in      = is_wr ? pattern : '0;
        ram.ram_address = (is_wr || is_rd) ? counter : '0;
        state_dbg       = state;
    end

    // Sequencer, address counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_pass <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WR0;
                        counter   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_addr <= '0;
                        fail_pass <= 1'b0;
                    end
                end
                WR0, WR1: begin
                    counter <= counter + AW'(1);
                    if (last) begin
                        state <= (state == WR0) ? RD0 : RD1;
                    end
                end
                RD0, RD1: begin
                    counter <= counter + AW'(1);
                    if (mismatch) begin
                        err_count <= err_next;
                        // Only the first mismatch of the whole run is recorded.
                        if (err_count == '0) begin
                            fail_addr <= counter;
                            fail_pass <= (state == RD1);
                        end
                    end
                    if (last) begin
                        if (state == RD0) begin
                            state <= WR1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // err_next includes a mismatch on the final word.
                            pass  <= (err_next == '0);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram512_bist.sv
// Directed bench for ram512_bist with a behavioural RAM512 and selectable read/address faults.
module tb_ram512_bist;
    import hack_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_count;
    logic [8:0]  fail_addr;
    logic        fail_pass;
    bist_state_t state_dbg;

    int n_checks;
    int n_fail;

    // 0 healthy, 1 ram_out[0] stuck at 0, 2 address bit 8 tied 0, 3 word 307 corrupt during RD1
    int          fault;
    logic        rd1_win;
    logic [15:0] mem [512];
    logic [8:0]  ea;
    logic [15:0] rd;

    ram512_bist_if bus ();

    ram512_bist dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ram       (bus.master),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_pass (fail_pass),
        .state_dbg (state_dbg)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational RAM read path with fault injection.
    always_comb begin
        ea = bus.ram_address;
        if (fault == 2) ea[8] = 1'b0;
        rd = mem[ea];
        if (fault == 1) rd[0] = 1'b0;
        if (fault == 3 && rd1_win && bus.ram_address == 9'd307) rd = 16'hFFFF;
        bus.ram_out = rd;
    end

    // RAM write port.
    always @(posedge clk) begin
        if (bus.ram_load) mem[ea] <= bus.ram_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state_dbg, IDLE); end
        n_checks++; if (bus.ram_address !== 9'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.ram_address); end
        n_checks++; if (bus.ram_in !== 16'h0000) begin n_fail++; $display("FAIL reset_ram_in got %h want 0000", bus.ram_in); end
        n_checks++; if (bus.ram_load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b want 0", bus.ram_load); end
        n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
        n_checks++; if (err_count !== 11'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err_count); end
        n_checks++; if ({fail_addr, fail_pass} !== 10'd0) begin n_fail++; $display("FAIL reset_fail_loc got %0d/%b want 0/0", fail_addr, fail_pass); end
    endtask

    task automatic test_healthy();
        int cyc;
        fault = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        n_checks++; if ({busy, bus.ram_load} !== 2'b11) begin n_fail++; $display("FAIL healthy_c1_busy_load got %b want 11", {busy, bus.ram_load}); end
        n_checks++; if (bus.ram_address !== 9'd0) begin n_fail++; $display("FAIL healthy_c1_addr got %0d want 0", bus.ram_address); end
        n_checks++; if (bus.ram_in !== 16'h3021) begin n_fail++; $display("FAIL healthy_c1_data got %h want 3021", bus.ram_in); end
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
            if (cyc == 2) begin
                n_checks++; if (bus.ram_in !== 16'h3020) begin n_fail++; $display("FAIL healthy_c2_data got %h want 3020", bus.ram_in); end
            end
            if (cyc == 512) begin
                n_checks++; if ({bus.ram_load, bus.ram_address} !== {1'b1, 9'd511}) begin n_fail++; $display("FAIL healthy_c512 got load=%b addr=%0d want 1/511", bus.ram_load, bus.ram_address); end
            end
            if (cyc == 513) begin
                n_checks++; if ({busy, bus.ram_load, bus.ram_address} !== {1'b1, 1'b0, 9'd0}) begin n_fail++; $display("FAIL healthy_c513 got busy=%b load=%b addr=%0d want 1/0/0", busy, bus.ram_load, bus.ram_address); end
            end
            if (cyc == 1024) begin
                n_checks++; if ({bus.ram_load, bus.ram_address} !== {1'b0, 9'd511}) begin n_fail++; $display("FAIL healthy_c1024 got load=%b addr=%0d want 0/511", bus.ram_load, bus.ram_address); end
            end
            if (cyc == 1025) begin
                n_checks++; if ({bus.ram_load, bus.ram_in} !== {1'b1, 16'hCFDE}) begin n_fail++; $display("FAIL healthy_c1025 got load=%b data=%h want 1/cfde", bus.ram_load, bus.ram_in); end
            end
            if (cyc == 2048) begin
                n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL healthy_c2048 got busy/done=%b want 10", {busy, done}); end
            end
        end
        n_checks++; if (cyc !== 2049) begin n_fail++; $display("FAIL healthy_done_cycle got %0d want 2049", cyc); end
        n_checks++; if ({busy, pass, err_count} !== {1'b0, 1'b1, 11'd0}) begin n_fail++; $display("FAIL healthy_result got busy=%b pass=%b err=%0d want 0/1/0", busy, pass, err_count); end
        n_checks++; if ({bus.ram_load, bus.ram_address} !== 10'd0) begin n_fail++; $display("FAIL healthy_done_bus got load=%b addr=%0d want 0/0", bus.ram_load, bus.ram_address); end
    endtask

    task automatic test_stuck_bit0();
        int cyc;
        fault = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== 2049) begin n_fail++; $display("FAIL stuck_done_cycle got %0d want 2049", cyc); end
        n_checks++; if (err_count !== 11'd512) begin n_fail++; $display("FAIL stuck_err got %0d want 512", err_count); end
        n_checks++; if ({fail_addr, fail_pass, pass} !== {9'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL stuck_loc got addr=%0d fpass=%b pass=%b want 0/0/0", fail_addr, fail_pass, pass); end
        fault = 0;
    endtask

    task automatic test_alias_bit8();
        int cyc;
        int err_after_rd0;
        fault = 2;
        err_after_rd0 = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
            if (cyc == 1025) err_after_rd0 = int'(err_count);
        end
        n_checks++; if (err_after_rd0 !== 256) begin n_fail++; $display("FAIL alias_err_pass0 got %0d want 256", err_after_rd0); end
        n_checks++; if (err_count !== 11'd512) begin n_fail++; $display("FAIL alias_err got %0d want 512", err_count); end
        n_checks++; if ({fail_addr, fail_pass, pass} !== {9'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL alias_loc got addr=%0d fpass=%b pass=%b want 0/0/0", fail_addr, fail_pass, pass); end
        fault = 0;
    endtask

    task automatic test_single_word();
        int cyc;
        fault = 3;
        rd1_win = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
            if (cyc == 1537) rd1_win = 1'b1;
        end
        rd1_win = 1'b0;
        n_checks++; if (cyc !== 2049) begin n_fail++; $display("FAIL single_done_cycle got %0d want 2049", cyc); end
        n_checks++; if (err_count !== 11'd1) begin n_fail++; $display("FAIL single_err got %0d want 1", err_count); end
        n_checks++; if ({fail_addr, fail_pass, pass} !== {9'd307, 1'b1, 1'b0}) begin n_fail++; $display("FAIL single_loc got addr=%0d fpass=%b pass=%b want 307/1/0", fail_addr, fail_pass, pass); end
        fault = 0;
    endtask

    task automatic test_mid_reset();
        int cyc;
        fault = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            tick();
            cyc++;
        end
        reset = 1'b1;
        tick();
        n_checks++; if ({busy, bus.ram_load, done} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags got busy=%b load=%b done=%b want 000", busy, bus.ram_load, done); end
        n_checks++; if ({state_dbg, err_count} !== {IDLE, 11'd0}) begin n_fail++; $display("FAIL midreset_state got st=%0d err=%0d want 0/0", state_dbg, err_count); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if ({state_dbg, busy} !== {IDLE, 1'b0}) begin n_fail++; $display("FAIL midreset_idle got st=%0d busy=%b want 0/0", state_dbg, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== 2049) begin n_fail++; $display("FAIL midreset_rerun_cycle got %0d want 2049", cyc); end
        n_checks++; if ({pass, err_count} !== {1'b1, 11'd0}) begin n_fail++; $display("FAIL midreset_rerun_result got pass=%b err=%0d want 1/0", pass, err_count); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        fault = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
            start = (cyc == 10 || cyc == 600);
            if (cyc == 11 || cyc == 601) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rebusy_busy_c%0d got %b want 1", cyc, busy); end
            end
            if (cyc == 601) begin
                n_checks++; if ({bus.ram_load, bus.ram_address} !== {1'b0, 9'd88}) begin n_fail++; $display("FAIL rebusy_c601 got load=%b addr=%0d want 0/88", bus.ram_load, bus.ram_address); end
            end
        end
        start = 1'b0;
        n_checks++; if (cyc !== 2049) begin n_fail++; $display("FAIL rebusy_done_cycle got %0d want 2049", cyc); end
        // start while in DONE launches a fresh run
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({done, busy, bus.ram_load, bus.ram_address} !== {1'b0, 1'b1, 1'b1, 9'd0}) begin n_fail++; $display("FAIL restart_from_done got done=%b busy=%b load=%b addr=%0d want 0/1/1/0", done, busy, bus.ram_load, bus.ram_address); end
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== 2049) begin n_fail++; $display("FAIL restart_done_cycle got %0d want 2049", cyc); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass got %b want 1", pass); end
    endtask

    // Test sequence and summary.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        fault    = 0;
        rd1_win  = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        test_reset();
        test_healthy();
        test_stuck_bit0();
        test_alias_bit8();
        test_single_word();
        test_mid_reset();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram512_bist.md
Name: ram512_bist

Overview:
- Memory initiator and self-test engine for RAM512. It drives the write side of the RAM interface (`in`, `load`, `address`) and consumes the read side (`out`).
- On `start` it runs two passes. Each pass writes a deterministic pattern to all 512 words, then reads every word back and compares it against the expected value.
- Pass/fail, error count and first-failure location are reported to the surrounding test harness or CPU-side status logic.

Parameters:
- AW, 9, address width (depth = 2**AW words).
- DW, 16, data width.
- SEED, 16'h3021, pattern seed (12321 decimal).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin test; sampled only in IDLE or DONE.
- ram_out  input  DW  RAM read data. RAM read is combinational from `ram_address` (no latency).
- ram_in  output  DW  RAM write data.
- ram_load  output  1  RAM write enable.
- ram_address  output  AW  RAM address.
- busy  output  1  test in progress.
- done  output  1  test finished; held until next start or reset.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  AW+2  total mismatches over both passes (max 1024, never overflows).
- fail_addr  output  AW  address of first mismatch.
- fail_pass  output  1  pass index (0/1) of first mismatch.

Behaviour:
- Clock and reset:
  - One clock domain, `clk`.
  - Reset is synchronous and active-high.
- Reset values (visible after the reset edge): state=IDLE, ram_address=0, ram_in=0, ram_load=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0, fail_pass=0.
- Pattern: P(a, k) = (SEED ^ zero-extended a) when k=0; ~(SEED ^ zero-extended a) when k=1.
- State machine: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE.
  - IDLE/DONE + start=1: next state WR0. Counter, err_count, fail_* and done are cleared; busy=1 from the next cycle.
  - WRk (one word per cycle): ram_address = counter, ram_in = P(counter, k), ram_load = 1.
    - Counter runs 0..2**AW-1, then wraps to 0 and the FSM moves to RDk.
  - RDk (one word per cycle): ram_address = counter, ram_load = 0.
    - ram_out is compared with P(counter, k) in the same cycle; a mismatch increments err_count at the edge.
    - The first mismatch of the whole run latches fail_addr and fail_pass.
    - At counter wrap: RD0 -> WR1, RD1 -> DONE.
  - DONE: busy=0, done=1, pass=(err_count==0), ram_load=0, ram_address=0.
- Timing: total busy time is exactly 4*2**AW cycles (2048 at the defaults). done rises on the cycle after the last RD1 compare.
- ram_load and ram_in are decoded from state and counter. ram_load is never 1 outside WR0/WR1.
- start while busy is ignored and does not restart the run.
- Reset mid-run returns to IDLE at the next edge. ram_load is 0 from that edge and all results are cleared. RAM contents are not touched.
- Simultaneous reset and start: reset wins.
- Mismatch on the last word of RD1 is still counted before DONE.

Decomposition:
- Shared package (hack_mem_pkg):
  - AW/DW constants.
  - State encoding IDLE=0, WR0=1, RD0=2, WR1=3, RD1=4, DONE=5.
  - SEED constant.
- Sub-module `bist_pattern`: combinational pattern generator (a, k) -> DW-bit P. Reused by write and compare paths.
- The top holds the FSM, the address counter and the result registers.

Test Plan:
- Healthy RAM512 attached, pulse start at cycle 0 -> busy=1 from cycle 1; ram_address 0..511 with ram_load=1 in cycles 1-512 and ram_load=0 in cycles 513-1024; done=1, pass=1, err_count=0 at cycle 2049.
- Stuck-at-0 on ram_out[0] via wrapper -> err_count=512, fail_pass=0, fail_addr=0, pass=0.
- Address bit 8 tied 0 in wrapper (aliasing) -> each pass fails addresses 0..255 only; err_count=512, fail_addr=0, fail_pass=0.
- Single-word corruption: force ram_out=16'hFFFF only when ram_address=9'd307 during RD1 -> err_count=1, fail_addr=307, fail_pass=1.
- Reset asserted at cycle 100 of a run, released at 102 -> cycle 101 onward: busy=0, ram_load=0, err_count=0; a new start then completes normally in 2048 busy cycles.
- start re-pulsed at cycles 10 and 600 during a run -> ignored, done still at cycle 2049. start in DONE -> done=0 next cycle and a new run begins.
